// File: rtl/akarin_ifetch.sv
// AKARIN instruction fetch front-end: fetch PC, SRAM read issue, prefetch FIFO and redirect flush.
// Define IFETCH_PERF_EN to build the fetch/flush performance counters.
module akarin_ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          IMEM_AW    = 12
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_re,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        inst_data,
    output logic [31:0]        inst_pc,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_flush_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   issue_pc_p1;
    logic          inflight_p1;
    logic [CW-1:0] count;
    logic [31:0]   qpc   [FIFO_DEPTH];
    logic [31:0]   qdata [FIFO_DEPTH];
    logic [31:0]   qpc_nxt   [FIFO_DEPTH];
    logic [31:0]   qdata_nxt [FIFO_DEPTH];
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occ;
    logic [CW-1:0] wptr;

    assign inst_valid = (count != '0) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    // Slots already claimed once this cycle's pop and in-flight response settle.
    assign occ        = {1'b0, count} + (CW+1)'(inflight_p1) - (CW+1)'(pop);
    assign issue      = !redirect_valid && (occ < (CW+1)'(FIFO_DEPTH));
    assign push       = inflight_p1 && !redirect_valid;
    assign wptr       = count - CW'(pop);

    assign imem_re    = issue && !rst;
    assign imem_addr  = rst ? '0 : fetch_pc[IMEM_AW+1:2];
    assign inst_data  = qdata[0];
    assign inst_pc    = qpc[0];

    // Shift-register FIFO: entry 0 is always the head, so outputs come straight from flops.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            qpc_nxt[i]   = qpc[i];
            qdata_nxt[i] = qdata[i];
        end
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                qpc_nxt[i]   = qpc[i+1];
                qdata_nxt[i] = qdata[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (CW'(i) == wptr) begin
                    qpc_nxt[i]   = issue_pc_p1;
                    qdata_nxt[i] = imem_rdata;
                end
            end
        end
    end

    // Issue stage -> response stage (p1) -> FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            issue_pc_p1 <= '0;
            inflight_p1 <= 1'b0;
            count       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                qpc[i]   <= '0;
                qdata[i] <= '0;
            end
        end else begin
            if (redirect_valid) begin
                fetch_pc    <= redirect_pc & ~32'h3;
                inflight_p1 <= 1'b0;
                count       <= '0;
            end else begin
                inflight_p1 <= issue;
                count       <= count + CW'(push) - CW'(pop);
                if (issue) begin
                    issue_pc_p1 <= fetch_pc;
                    fetch_pc    <= fetch_pc + 32'd4;
                end
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                qpc[i]   <= qpc_nxt[i];
                qdata[i] <= qdata_nxt[i];
            end
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (imem_re)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_valid)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule
